// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and channel FSM encodings.
// Used by both the register-file slave and the existing master.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/axi4lite_regfile_slave_if.sv
// AXI4-Lite bus bundle without strobes; the clock and reset stay as plain ports.
interface axi4lite_regfile_slave_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi4lite_regfile.sv
// Register storage with range/read-only decode: one write port, one async read port.
// Register 0 is a constant ID word; registers 1..NREG-1 are read/write.
module axi4lite_regfile
  import axi4lite_pkg::*;
#(
  parameter int          NREG     = 16,
  parameter logic [31:0] ID_VALUE = 32'hA411_0001
) (
  input  logic                 aclk,
  input  logic                 arestn,
  input  logic                 we,
  input  logic [29:0]          widx,
  input  logic [31:0]          wdata,
  output resp_e                wresp,
  input  logic [29:0]          ridx,
  output logic [31:0]          rdata,
  output resp_e                rresp,
  output logic [NREG*32-1:0]   reg_dump
);

  localparam int IW = $clog2(NREG);

  logic [31:0] mem   [1:NREG-1];
  logic [31:0] words [NREG];
  logic        w_in_range;
  logic        r_in_range;

  assign w_in_range = (widx < 30'(NREG));
  assign r_in_range = (ridx < 30'(NREG));

  always_comb begin
    wresp = RESP_OKAY;
    if (!w_in_range) begin
      wresp = RESP_DECERR;
    end else if (widx == 30'd0) begin
      wresp = RESP_SLVERR;
    end
  end

  // Only legal writes touch storage; DECERR/SLVERR accesses are side-effect free.
  always_ff @(posedge aclk) begin
    if (!arestn) begin
      for (int i = 1; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wresp == RESP_OKAY)) begin
      mem[widx[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    words[0] = ID_VALUE;
    for (int i = 1; i < NREG; i++) begin
      words[i] = mem[i];
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_dump
    assign reg_dump[g*32 +: 32] = words[g];
  end

  always_comb begin
    rdata = '0;
    rresp = RESP_DECERR;
    if (r_in_range) begin
      rdata = words[ridx[IW-1:0]];
      rresp = RESP_OKAY;
    end
  end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register-file slave: independent read and write channel FSMs
// around the axi4lite_regfile storage block.
module axi4lite_regfile_slave
  import axi4lite_pkg::*;
#(
  parameter int          NREG     = 16,
  parameter logic [31:0] ID_VALUE = 32'hA411_0001
) (
  input  logic                     aclk,
  input  logic                     arestn,
  axi4lite_regfile_slave_if.slave  axi,
  output logic [NREG*32-1:0]       reg_dump
);

  wstate_e     wstate;
  rstate_e     rstate;
  logic        aw_held;
  logic        w_held;
  logic [29:0] awidx_q;
  logic [31:0] wdata_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic [29:0] widx;
  logic [31:0] wdata_sel;
  resp_e       rf_wresp;
  resp_e       rf_rresp;
  logic [31:0] rf_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{axi.araddr[1:0], axi.awaddr[1:0]};

  // Readies derive only from registered state, never from the same channel's valid.
  assign axi.awready = (wstate == W_IDLE) && !aw_held;
  assign axi.wready  = (wstate == W_IDLE) && !w_held;
  assign axi.arready = (rstate == R_IDLE);
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;

  assign aw_hs     = axi.awvalid && axi.awready;
  assign w_hs      = axi.wvalid && axi.wready;
  assign ar_hs     = axi.arvalid && axi.arready;
  assign commit    = (aw_held || aw_hs) && (w_held || w_hs);
  assign widx      = aw_held ? awidx_q : word_index(axi.awaddr);
  assign wdata_sel = w_held ? wdata_q : axi.wdata;

  axi4lite_regfile #(
    .NREG     (NREG),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .aclk     (aclk),
    .arestn   (arestn),
    .we       (commit),
    .widx     (widx),
    .wdata    (wdata_sel),
    .wresp    (rf_wresp),
    .ridx     (word_index(axi.araddr)),
    .rdata    (rf_rdata),
    .rresp    (rf_rresp),
    .reg_dump (reg_dump)
  );

  always_ff @(posedge aclk) begin
    if (!arestn) begin
      wstate   <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awidx_q  <= '0;
      wdata_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= rf_wresp;
            wstate   <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              awidx_q <= word_index(axi.awaddr);
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_q <= axi.wdata;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bvalid_q <= 1'b0;
            wstate   <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // rf_rdata is sampled before the same-edge write lands, so reads see the old value.
  always_ff @(posedge aclk) begin
    if (!arestn) begin
      rstate   <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q  <= rf_rdata;
            rresp_q  <= rf_rresp;
            rvalid_q <= 1'b1;
            rstate   <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.rready) begin
            rvalid_q <= 1'b0;
            rstate   <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Randomized and directed bench for axi4lite_regfile_slave against an
// array-based register model.
module tb_axi4lite_regfile_slave;

  localparam int          NREG = 16;
  localparam logic [31:0] ID   = 32'hA411_0001;
  localparam int          DW   = NREG * 32;

  logic          aclk;
  logic          arestn;
  logic [DW-1:0] reg_dump;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] model [NREG];

  axi4lite_regfile_slave_if axi ();

  axi4lite_regfile_slave #(.NREG(NREG), .ID_VALUE(ID)) dut (
    .aclk     (aclk),
    .arestn   (arestn),
    .axi      (axi),
    .reg_dump (reg_dump)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input bit is_wr);
    int unsigned idx = addr >> 2;
    if (idx >= NREG) return 2'b11;
    if (is_wr && idx == 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
    int unsigned idx = addr >> 2;
    if (idx >= NREG) return 32'h0;
    if (idx == 0) return ID;
    return model[idx];
  endfunction

  function automatic logic [DW-1:0] exp_dump();
    logic [DW-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*32 +: 32] = (i == 0) ? ID : model[i];
    return v;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data);
    if (exp_resp(addr, 1'b1) == 2'b00) model[addr >> 2] = data;
  endfunction

  task automatic do_reset();
    arestn = 1'b0;
    @(posedge aclk); #1;
    arestn = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    axi.awaddr = addr;
    axi.wdata  = data;
    while (!(aw_done && w_done) && cyc < 50) begin
      axi.awvalid = !aw_done && (cyc >= aw_dly);
      axi.wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      chk("bvalid_early", axi.bvalid, 0);
      @(posedge aclk); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    chk("b_latency", axi.bvalid, 1);
    for (int i = 0; i < 10 && !axi.bvalid; i++) begin
      @(posedge aclk); #1;
    end
    chk("bresp", axi.bresp, exp_resp(addr, 1'b1));
    model_write(addr, data);
    axi.bready = 1'b1;
    @(posedge aclk); #1;
    axi.bready = 1'b0;
    chk("dump_after_wr", reg_dump, exp_dump());
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly);
    bit done = 0, hs;
    int cyc = 0;
    axi.araddr = addr;
    while (!done && cyc < 50) begin
      axi.arvalid = (cyc >= ar_dly);
      hs = axi.arvalid && axi.arready;
      @(posedge aclk); #1;
      done = hs;
      cyc++;
    end
    axi.arvalid = 1'b0;
    chk("r_latency", axi.rvalid, 1);
    chk("rdata", axi.rdata, exp_rdata(addr));
    chk("rresp", axi.rresp, exp_resp(addr, 1'b0));
    axi.rready = 1'b1;
    @(posedge aclk); #1;
    axi.rready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] old3;
    logic [DW-1:0] d0;
    logic [1:0] b0, r0;
    logic [31:0] rd0;

    axi.araddr = '0;  axi.arvalid = 0; axi.rready = 0;
    axi.awaddr = '0;  axi.awvalid = 0; axi.wdata = '0;
    axi.wvalid = 0;   axi.bready  = 0;
    arestn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    do_reset();

    chk("rst_rvalid",  axi.rvalid, 0);
    chk("rst_bvalid",  axi.bvalid, 0);
    chk("rst_rdata",   axi.rdata, 0);
    chk("rst_rresp",   axi.rresp, 0);
    chk("rst_bresp",   axi.bresp, 0);
    chk("rst_awready", axi.awready, 1);
    chk("rst_wready",  axi.wready, 1);
    chk("rst_arready", axi.arready, 1);
    chk("rst_dump",    reg_dump, exp_dump());

    // Same-cycle AW/W, then read back.
    axi_write(32'h4, 32'hDEAD_BEEF, 0, 0);
    axi_read(32'h4, 0);
    // W three cycles ahead of AW.
    axi_write(32'h8, 32'h1234_5678, 3, 0);
    axi_read(32'h8, 0);
    // Read-only ID register.
    axi_write(32'h0, 32'h55, 0, 0);
    axi_read(32'h0, 0);
    // Out-of-range accesses.
    d0 = reg_dump;
    axi_read(32'h40, 0);
    axi_write(32'h44, 32'hCAFE_F00D, 1, 0);
    chk("decerr_dump_same", reg_dump, d0);
    // Ignored low address bits.
    axi_write(32'h17, 32'hA5A5_0505, 0, 2);
    axi_read(32'h14, 1);

    // Concurrent write and read of reg 3 on the same edge, then stall responses.
    axi_write(32'hC, 32'h1111_2222, 0, 0);
    old3 = model[3];
    axi.awaddr = 32'hC; axi.wdata = 32'h3333_4444; axi.araddr = 32'hC;
    axi.awvalid = 1; axi.wvalid = 1; axi.arvalid = 1;
    @(posedge aclk); #1;
    model_write(32'hC, 32'h3333_4444);
    chk("raw_old_value", axi.rdata, old3);
    b0 = axi.bresp; r0 = axi.rresp; rd0 = axi.rdata;
    axi.awaddr = 32'h10; axi.araddr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      chk("stall_bvalid",  axi.bvalid, 1);
      chk("stall_rvalid",  axi.rvalid, 1);
      chk("stall_bresp",   axi.bresp, b0);
      chk("stall_rresp",   axi.rresp, r0);
      chk("stall_rdata",   axi.rdata, rd0);
      chk("stall_readies", {axi.awready, axi.wready, axi.arready}, 3'b000);
    end
    axi.bready = 1; axi.rready = 1;
    @(posedge aclk); #1;
    axi.bready = 0; axi.rready = 0;
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
    chk("stall_dump", reg_dump, exp_dump());
    axi_read(32'h10, 0);

    // Reset after AW accepted but before W.
    axi.awaddr = 32'h18; axi.awvalid = 1;
    @(posedge aclk); #1;
    axi.awvalid = 0;
    do_reset();
    chk("midrst_bvalid",  axi.bvalid, 0);
    chk("midrst_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);
    chk("midrst_dump",    reg_dump, exp_dump());
    axi.wdata = 32'h7777_8888; axi.wvalid = 1;
    @(posedge aclk); #1;
    axi.wvalid = 0;
    repeat (3) begin
      @(posedge aclk); #1;
      chk("midrst_no_b", axi.bvalid, 0);
    end
    axi.awaddr = 32'h1C; axi.awvalid = 1;
    @(posedge aclk); #1;
    axi.awvalid = 0;
    chk("midrst_resume_b", axi.bvalid, 1);
    chk("midrst_resume_resp", axi.bresp, 2'b00);
    model_write(32'h1C, 32'h7777_8888);
    axi.bready = 1;
    @(posedge aclk); #1;
    axi.bready = 0;
    chk("midrst_resume_dump", reg_dump, exp_dump());

    // Random traffic, including out-of-range and ID-register hits.
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, NREG + 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
